// File: rtl/line_raster_writer_pkg.sv
// Shared types and constants for the line rasterizer: FSM states, coordinate
// widths, default frame size and the widths of the Bresenham error terms.
package line_raster_writer_pkg;

  localparam int X_W       = 11;
  localparam int Y_W       = 10;
  localparam int H_RES_DEF = 1280;
  localparam int V_RES_DEF = 720;
  localparam int D_W       = 13;   // dx, dy, err
  localparam int E2_W      = 14;   // 2*err

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    DRAW  = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/line_raster_writer_fb_addr_calc.sv
// Registered linear frame-buffer address y*H_RES + x. It loads on the same
// enable as the pixel coordinate registers, so addr_out stays aligned with them.
module fb_addr_calc
  import line_raster_writer_pkg::*;
#(
  parameter int H_RES  = H_RES_DEF,
  parameter int ADDR_W = 20
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              en_in,
  input  logic [X_W-1:0]    x_in,
  input  logic [Y_W-1:0]    y_in,
  output logic [ADDR_W-1:0] addr_out
);

  localparam logic [ADDR_W-1:0] H_MUL = ADDR_W'(H_RES);

  logic [ADDR_W-1:0] r_addr;

  // Clipped points produce a truncated, meaningless address; it is never written.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_addr <= '0;
    end else if (en_in) begin
      r_addr <= ADDR_W'(y_in) * H_MUL + ADDR_W'(x_in);
    end
  end

  assign addr_out = r_addr;

endmodule

// File: rtl/line_raster_writer.sv
// Bresenham line rasterizer: walks a line in any octant and emits one pixel
// write (x, y, linear address, colour) per cycle on a valid/ready stream.
module line_raster_writer
  import line_raster_writer_pkg::*;
#(
  parameter int H_RES   = H_RES_DEF,
  parameter int V_RES   = V_RES_DEF,
  parameter int ADDR_W  = $clog2(H_RES * V_RES),
  parameter int COLOR_W = 24
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               start_in,
  input  logic [X_W-1:0]     x1_in,
  input  logic [Y_W-1:0]     y1_in,
  input  logic [X_W-1:0]     x2_in,
  input  logic [Y_W-1:0]     y2_in,
  input  logic [COLOR_W-1:0] color_in,
  output logic               busy_out,
  output logic               done_out,
  output logic               pixel_valid_out,
  input  logic               pixel_ready_in,
  output logic [X_W-1:0]     x_out,
  output logic [Y_W-1:0]     y_out,
  output logic [ADDR_W-1:0]  addr_out,
  output logic [COLOR_W-1:0] color_out,
  output logic [1:0]         dbg_state_out
);

  // Write stream: a pixel transfers on a cycle where pixel_valid_out and
  // pixel_ready_in are both high. Once valid is raised, valid and the pixel
  // fields hold unchanged until that transfer; valid only drops after it.

  state_t               r_state;
  logic                 r_req;
  logic [X_W-1:0]       r_x1, r_x2, r_x;
  logic [Y_W-1:0]       r_y1, r_y2, r_y;
  logic signed [D_W-1:0] r_dx, r_dy, r_err;
  logic                 r_busy, r_done, r_valid;
  logic [COLOR_W-1:0]   r_color;

  logic                  w_sx_neg, w_sy_neg;
  logic [X_W-1:0]        w_dx_mag;
  logic [Y_W-1:0]        w_dy_mag;
  logic signed [D_W-1:0] w_setup_dx, w_setup_dy, w_setup_err;
  logic signed [E2_W-1:0] w_e2, w_dx_ext, w_dy_ext;
  logic                  w_step_x, w_step_y;
  logic [X_W-1:0]        w_next_x, w_load_x;
  logic [Y_W-1:0]        w_next_y, w_load_y;
  logic signed [D_W-1:0] w_next_err;
  logic                  w_step_done, w_at_end, w_load;

  function automatic logic in_frame(input logic [X_W-1:0] x, input logic [Y_W-1:0] y);
    return (int'(x) < H_RES) && (int'(y) < V_RES);
  endfunction

  // Step directions are fixed by the latched endpoints for the whole line.
  assign w_sx_neg    = (r_x2 < r_x1);
  assign w_sy_neg    = (r_y2 < r_y1);
  assign w_dx_mag    = w_sx_neg ? (r_x1 - r_x2) : (r_x2 - r_x1);
  assign w_dy_mag    = w_sy_neg ? (r_y1 - r_y2) : (r_y2 - r_y1);
  assign w_setup_dx  = {{(D_W - X_W){1'b0}}, w_dx_mag};
  assign w_setup_dy  = -{{(D_W - Y_W){1'b0}}, w_dy_mag};
  assign w_setup_err = w_setup_dx + w_setup_dy;

  assign w_e2     = {r_err, 1'b0};
  assign w_dx_ext = {r_dx[D_W-1], r_dx};
  assign w_dy_ext = {r_dy[D_W-1], r_dy};
  assign w_step_x = (w_e2 >= w_dy_ext);
  assign w_step_y = (w_e2 <= w_dx_ext);

  // Both axis updates are decided from the pre-step error term.
  always_comb begin
    w_next_x   = r_x;
    w_next_y   = r_y;
    w_next_err = r_err;
    if (w_step_x) begin
      w_next_err = w_next_err + r_dy;
      w_next_x   = w_sx_neg ? (r_x - X_W'(1)) : (r_x + X_W'(1));
    end
    if (w_step_y) begin
      w_next_err = w_next_err + r_dx;
      w_next_y   = w_sy_neg ? (r_y - Y_W'(1)) : (r_y + Y_W'(1));
    end
  end

  // A clipped point never raises valid, so it retires in its single cycle.
  assign w_step_done = r_valid ? pixel_ready_in : 1'b1;
  assign w_at_end    = (r_x == r_x2) && (r_y == r_y2);

  always_comb begin
    w_load   = 1'b0;
    w_load_x = w_next_x;
    w_load_y = w_next_y;
    if (r_state == SETUP) begin
      w_load   = 1'b1;
      w_load_x = r_x1;
      w_load_y = r_y1;
    end else if ((r_state == DRAW) && w_step_done && !w_at_end) begin
      w_load = 1'b1;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state <= IDLE;
      r_req   <= 1'b0;
      r_x1    <= '0;
      r_y1    <= '0;
      r_x2    <= '0;
      r_y2    <= '0;
      r_x     <= '0;
      r_y     <= '0;
      r_dx    <= '0;
      r_dy    <= '0;
      r_err   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_valid <= 1'b0;
      r_color <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_busy <= 1'b0;
          r_done <= 1'b0;
          // The request is captured on one edge and acted on the next.
          if (r_req) begin
            r_req   <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= SETUP;
          end else if (start_in) begin
            r_req   <= 1'b1;
            r_x1    <= x1_in;
            r_y1    <= y1_in;
            r_x2    <= x2_in;
            r_y2    <= y2_in;
            r_color <= color_in;
          end
        end
        SETUP: begin
          r_dx    <= w_setup_dx;
          r_dy    <= w_setup_dy;
          r_err   <= w_setup_err;
          r_x     <= w_load_x;
          r_y     <= w_load_y;
          r_valid <= in_frame(w_load_x, w_load_y);
          r_state <= DRAW;
        end
        DRAW: begin
          if (w_step_done) begin
            if (w_at_end) begin
              r_valid <= 1'b0;
              r_done  <= 1'b1;
              r_state <= DONE;
            end else begin
              r_x     <= w_load_x;
              r_y     <= w_load_y;
              r_err   <= w_next_err;
              r_valid <= in_frame(w_load_x, w_load_y);
            end
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  fb_addr_calc #(
    .H_RES  (H_RES),
    .ADDR_W (ADDR_W)
  ) u_addr (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .en_in    (w_load),
    .x_in     (w_load_x),
    .y_in     (w_load_y),
    .addr_out (addr_out)
  );

  assign busy_out        = r_busy;
  assign done_out        = r_done;
  assign pixel_valid_out = r_valid;
  assign x_out           = r_x;
  assign y_out           = r_y;
  assign color_out       = r_color;
  assign dbg_state_out   = r_state;

endmodule

// File: tb/tb_line_raster_writer.sv
// Bench for line_raster_writer: a Bresenham reference model fills an expected
// pixel queue, a monitor pops it on every write handshake.
module tb_line_raster_writer;
  import line_raster_writer_pkg::*;

  localparam int H  = 1280;
  localparam int V  = 720;
  localparam int AW = 20;
  localparam int CW = 24;
  localparam int PW = X_W + Y_W + AW + CW;

  logic          clk = 1'b0;
  logic          rst;
  logic          start_in;
  logic [X_W-1:0] x1_in, x2_in;
  logic [Y_W-1:0] y1_in, y2_in;
  logic [CW-1:0] color_in;
  logic          busy_out, done_out, pixel_valid_out, pixel_ready_in;
  logic [X_W-1:0] x_out;
  logic [Y_W-1:0] y_out;
  logic [AW-1:0] addr_out;
  logic [CW-1:0] color_out;
  logic [1:0]    dbg_state;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int ready_mode = 0;
  int ready_idx = 0;

  logic [PW-1:0] exp_q[$];

  line_raster_writer #(
    .H_RES   (H),
    .V_RES   (V),
    .ADDR_W  (AW),
    .COLOR_W (CW)
  ) dut (
    .clk_in          (clk),
    .rst_in          (rst),
    .start_in        (start_in),
    .x1_in           (x1_in),
    .y1_in           (y1_in),
    .x2_in           (x2_in),
    .y2_in           (y2_in),
    .color_in        (color_in),
    .busy_out        (busy_out),
    .done_out        (done_out),
    .pixel_valid_out (pixel_valid_out),
    .pixel_ready_in  (pixel_ready_in),
    .x_out           (x_out),
    .y_out           (y_out),
    .addr_out        (addr_out),
    .color_out       (color_out),
    .dbg_state_out   (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] need);
    checks++;
    if (got !== need) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, need);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic int clampi(input int v, input int lo, input int hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  task automatic model_line(input int x1, input int y1, input int x2, input int y2,
                            input logic [CW-1:0] c);
    int dx, dy, sx, sy, err, e2, x, y;
    dx  = iabs(x2 - x1);
    dy  = -iabs(y2 - y1);
    sx  = (x2 >= x1) ? 1 : -1;
    sy  = (y2 >= y1) ? 1 : -1;
    err = dx + dy;
    x   = x1;
    y   = y1;
    forever begin
      if (x < H && y < V)
        exp_q.push_back({X_W'(x), Y_W'(y), AW'(y * H + x), c});
      if (x == x2 && y == y2) break;
      e2 = 2 * err;
      if (e2 >= dy) begin err += dy; x += sx; end
      if (e2 <= dx) begin err += dx; y += sy; end
    end
  endtask

  // ---------------- ready driver ----------------
  initial begin
    pixel_ready_in = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0: pixel_ready_in = 1'b1;
        1: begin
          pixel_ready_in = ((ready_idx % 4) == 0) || ((ready_idx % 4) == 3);
          ready_idx++;
        end
        default: pixel_ready_in = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic          prev_stall;
    logic [PW-1:0] prev_pix, cur, exp;
    prev_stall = 1'b0;
    prev_pix   = '0;
    forever begin
      @(negedge clk);
      if (rst !== 1'b0) begin
        prev_stall = 1'b0;
      end else begin
        cur = {x_out, y_out, addr_out, color_out};
        if (prev_stall) begin
          checks++;
          if (!(pixel_valid_out === 1'b1 && cur === prev_pix)) begin
            errors++;
            $display("FAIL stall_hold: got valid=%0b pix=%h, expected valid=1 pix=%h",
                     pixel_valid_out, cur, prev_pix);
          end
        end
        if (pixel_valid_out === 1'b1 && pixel_ready_in === 1'b1) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL extra_pixel: got x=%0d y=%0d, expected no write", x_out, y_out);
          end else begin
            exp = exp_q.pop_front();
            if (cur !== exp) begin
              errors++;
              $display("FAIL pixel: got x=%0d y=%0d addr=%0d col=%h, expected x=%0d y=%0d addr=%0d col=%h",
                       x_out, y_out, addr_out, color_out,
                       exp[PW-1 -: X_W], exp[PW-X_W-1 -: Y_W], exp[CW +: AW], exp[CW-1:0]);
            end
          end
        end
        prev_stall = (pixel_valid_out === 1'b1) && (pixel_ready_in !== 1'b1);
        prev_pix   = cur;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic issue_start(input int x1, input int y1, input int x2, input int y2,
                             input logic [CW-1:0] c);
    @(posedge clk); #1;
    x1_in    = X_W'(x1);
    y1_in    = Y_W'(y1);
    x2_in    = X_W'(x2);
    y2_in    = Y_W'(y2);
    color_in = c;
    start_in = 1'b1;
  endtask

  task automatic draw_line(input int x1, input int y1, input int x2, input int y2,
                           input int mode, input bit poke_start);
    int n, t0;
    bit got_done;
    logic [CW-1:0] c;
    c = CW'($urandom);
    n = ((iabs(x2 - x1) > iabs(y2 - y1)) ? iabs(x2 - x1) : iabs(y2 - y1)) + 1;
    ready_mode = mode;
    ready_idx  = 0;
    model_line(x1, y1, x2, y2, c);
    issue_start(x1, y1, x2, y2, c);
    t0 = cyc + 1;
    @(posedge clk); #1;
    start_in = 1'b0;
    check("busy_edge0", busy_out, 0);
    @(posedge clk); #1;
    check("busy_edge1", busy_out, 1);
    check("valid_edge1", pixel_valid_out, 0);
    @(posedge clk); #1;
    check("valid_edge2", pixel_valid_out, (x1 < H && y1 < V) ? 1 : 0);
    got_done = 1'b0;
    for (int i = 0; i < 8000 && !got_done; i++) begin
      @(negedge clk);
      start_in = poke_start && (i == 1);
      if (done_out === 1'b1) got_done = 1'b1;
    end
    if (!got_done) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done_out, expected one within 8000 cycles");
      exp_q.delete();
    end else if (mode == 0) begin
      check("done_edge", cyc - t0, 2 + n);
    end
    @(negedge clk);
    start_in = 1'b0;
    check("done_pulse", done_out, 0);
    check("busy_fall", busy_out, 0);
    check("pixels_left", exp_q.size(), 0);
    if (poke_start) begin
      repeat (6) @(negedge clk);
      check("poke_ignored", {busy_out, pixel_valid_out}, 0);
    end
  endtask

  task automatic reset_mid_line();
    ready_mode = 0;
    model_line(0, 0, 200, 100, 24'h5a5a5a);
    issue_start(0, 0, 200, 100, 24'h5a5a5a);
    @(posedge clk); #1;
    start_in = 1'b0;
    repeat (12) @(posedge clk);
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    check("rst_busy", busy_out, 0);
    check("rst_done", done_out, 0);
    check("rst_valid", pixel_valid_out, 0);
    check("rst_x", x_out, 0);
    check("rst_y", y_out, 0);
    check("rst_addr", addr_out, 0);
    check("rst_color", color_out, 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int bx, by, ox, oy, xa, ya, xb, yb;
    rst      = 1'b1;
    start_in = 1'b0;
    x1_in    = '0;
    y1_in    = '0;
    x2_in    = '0;
    y2_in    = '0;
    color_in = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", busy_out, 0);
    check("reset_done", done_out, 0);
    check("reset_valid", pixel_valid_out, 0);
    check("reset_xy", {x_out, y_out}, 0);
    check("reset_addr", addr_out, 0);
    check("reset_color", color_out, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    draw_line(0, 0, 3, 0, 0, 1'b0);        // horizontal
    draw_line(5, 9, 3, 3, 0, 1'b0);        // steep, reversed
    draw_line(0, 0, 3, 3, 1, 1'b0);        // backpressure 1,0,0,1
    draw_line(1278, 5, 1281, 5, 0, 1'b0);  // right-edge clip
    draw_line(7, 7, 7, 7, 0, 1'b1);        // degenerate, start during DONE
    draw_line(10, 10, 40, 20, 0, 1'b1);    // start during DRAW
    reset_mid_line();
    draw_line(2, 3, 9, 1, 2, 1'b0);

    for (int k = 0; k < 24; k++) begin
      bx = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1230, 1300)) : int'($urandom_range(0, 2047));
      by = ($urandom_range(0, 1) == 1) ? int'($urandom_range(690, 750)) : int'($urandom_range(0, 1023));
      ox = $urandom_range(0, 60);
      oy = $urandom_range(0, 60);
      xa = clampi(bx + ox - 30, 0, 2047);
      ya = clampi(by + oy - 30, 0, 1023);
      ox = $urandom_range(0, 60);
      oy = $urandom_range(0, 60);
      xb = clampi(bx + ox - 30, 0, 2047);
      yb = clampi(by + oy - 30, 0, 1023);
      draw_line(xa, ya, xb, yb, $urandom_range(0, 2), 1'b0);
    end

    repeat (4) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/line_raster_writer.md
# line_raster_writer

Bresenham line rasterizer that writes pixels into the frame buffer. Given two endpoints, it walks the line in any octant and emits one pixel per cycle as a valid/ready write stream: x, y, linear address and colour. It sits between the geometry/control logic and the frame-buffer BRAM write port. It is the producer-side counterpart of the beam-chasing line sprites, which only render pixels as the scan passes over them.

## Interface
Parameters:
- H_RES, 1280, horizontal resolution; pixels with x >= H_RES are clipped.
- V_RES, 720, vertical resolution; pixels with y >= V_RES are clipped.
- ADDR_W, $clog2(H_RES*V_RES), frame-buffer address width.
- COLOR_W, 24, colour width.

Ports (one clock; reset is asynchronous and active-high):
- clk_in, input, 1, system clock.
- rst_in, input, 1, asynchronous active-high reset.
- start_in, input, 1, request a line draw; sampled only in IDLE.
- x1_in, input, 11, start x, unsigned.
- y1_in, input, 10, start y, unsigned.
- x2_in, input, 11, end x, unsigned.
- y2_in, input, 10, end y, unsigned.
- color_in, input, COLOR_W, line colour; latched with start.
- busy_out, output, 1, high from the cycle after start is accepted until DONE exits.
- done_out, output, 1, one-cycle pulse when the line is complete.
- pixel_valid_out, output, 1, write request valid.
- pixel_ready_in, input, 1, frame-buffer port accepts the write.
- x_out, output, 11, pixel x.
- y_out, output, 10, pixel y.
- addr_out, output, ADDR_W, y*H_RES + x.
- color_out, output, COLOR_W, latched colour.

## Operation
- FSM states: IDLE, SETUP, DRAW, DONE.
- IDLE:
  - start_in=1 latches the endpoints and colour, then goes to SETUP.
  - Start is ignored in all other states.
- SETUP (1 cycle) computes:
  - dx = |x2-x1|, dy = -|y2-y1|
  - sx = x2>=x1 ? +1 : -1, sy = y2>=y1 ? +1 : -1
  - err = dx + dy
  - current point = (x1, y1).
- DRAW, per step on the current point:
  - e2 = 2*err.
  - If e2 >= dy: err += dy, x += sx.
  - If e2 <= dx: err += dx, y += sy.
  - Both updates use the pre-step err.
- Step termination:
  - A step completes on a handshake (valid && ready).
  - For clipped points, the step completes unconditionally.
  - Completing the step at the endpoint (x==x2 and y==y2) goes to DONE; otherwise the FSM steps.
- Clipping:
  - A point with x >= H_RES or y >= V_RES keeps pixel_valid_out low.
  - Such a point still consumes one cycle.
- DONE (1 cycle): done_out=1, busy_out stays 1, then returns to IDLE.
- Arithmetic:
  - dx, dy, err are 13-bit signed; e2 is 14-bit signed.
  - These widths never overflow for 11/10-bit coordinates.
  - The x/y step registers are wide enough to hold the endpoint without wrap.
- Pixel count is max(|x2-x1|, |y2-y1|) + 1, counting clipped points.

## Timing
- Reset values: busy_out=0, done_out=0, pixel_valid_out=0, x_out=0, y_out=0, addr_out=0, color_out=0; FSM in IDLE.
- Latency, with start sampled high in IDLE at cycle edge 0:
  - busy_out=1 at edge 1 (SETUP).
  - First pixel_valid_out at edge 2.
- All outputs are registered.
- Throughput: one pixel per cycle while pixel_ready_in=1.
- Backpressure:
  - While valid=1 and ready=0, x_out/y_out/addr_out/color_out/valid hold stable.
  - Valid never drops without a handshake.
- done_out pulses the cycle after the final handshake or final clipped step.
- busy_out falls the cycle after done_out.
- Start in DONE is ignored; the earliest accepted restart is the first IDLE cycle.
- Reset asserted mid-line immediately returns to reset values and abandons the line.
- Degenerate line (x1==x2 and y1==y2): exactly one pixel, then DONE.

## Structure
- Shared package holds:
  - the state enum (IDLE/SETUP/DRAW/DONE)
  - coordinate width constants (X_W=11, Y_W=10)
  - H_RES/V_RES defaults.
- Optional sub-module `fb_addr_calc`: registered y*H_RES+x with 1-cycle latency. It must be pipelined so addr_out stays aligned with x_out/y_out. Everything else is single-module.

## Test plan
- Horizontal line, ready=1: (0,0)->(3,0) -> pixels (0,0),(1,0),(2,0),(3,0) on consecutive cycles from edge 2; done_out one cycle after the 4th; addr 0,1,2,3.
- Steep reverse line: (5,9)->(3,3) -> exactly (5,9),(5,8),(4,7),(4,6),(4,5),(3,4),(3,3).
- Backpressure: ready toggled 1,0,0,1,… on (0,0)->(3,3) -> outputs held while stalled; each of (0,0),(1,1),(2,2),(3,3) is written exactly once.
- Clipping with H_RES=1280: (1278,5)->(1281,5) -> only (1278,5),(1279,5) are valid (addr 7678, 7679); done at edge 2+4.
- Degenerate line and start-while-busy:
  - (7,7)->(7,7) -> single pixel, then done.
  - A second start pulsed during DRAW is ignored.
- Reset mid-line: assert rst_in during DRAW -> all outputs 0 in the same cycle; a fresh start afterwards draws correctly.
